// File: rtl/register_bank.sv
// Bank of DEPTH registers on a shared tri-state bus. It supports addressed write,
// in-place inc/dec with a wrap pulse, a one-cycle registered read window, and a sticky re/we conflict flag.
module register_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic             we,
    input  logic             inc,
    input  logic             dec,
    input  logic [AW-1:0]    addr,
    input  logic [AW-1:0]    tap_addr,
    inout  wire  [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             wrap,
    output logic             err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] rd_latch;
    logic             drive_en;
    logic             addr_ok;
    logic             tap_ok;
    logic [WIDTH-1:0] cur;

    // Out-of-range slots only exist when DEPTH is not a power of two.
    assign addr_ok = ({1'b0, addr} < DEPTH_L);
    assign tap_ok  = ({1'b0, tap_addr} < DEPTH_L);

    always_comb begin
        cur = '0;
        if (addr_ok) cur = regs[addr];
    end

    always_comb begin
        q = '0;
        if (tap_ok) q = regs[tap_addr];
    end

    assign zero = (q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            rd_latch <= '0;
            drive_en <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (addr_ok) begin
                if (we) begin
                    regs[addr] <= data_bus;
                end else if (inc && !dec) begin
                    regs[addr] <= cur + 1'b1;
                    wrap       <= &cur;
                end else if (dec && !inc) begin
                    regs[addr] <= cur - 1'b1;
                    wrap       <= (cur == '0);
                end
            end
            // A write owns the bus, so a simultaneous read is dropped.
            drive_en <= re && !we;
            if (re && !we) rd_latch <= cur;
            if (re && we) err <= 1'b1;
        end
    end

    assign data_bus = drive_en ? rd_latch : {WIDTH{1'bz}};

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, sharing one bidirectional tri-state data bus. It is the generalised successor of the single 8-bit bus register in the datapath. It adds addressing, in-place increment/decrement with wrap detection for pointer and counter use, a registered bus-drive window, and sticky detection of read/write conflicts.

## Interface

- WIDTH, 8, bits per register and data bus width
- DEPTH, 4, number of registers; must be ≥2
- AW, $clog2(DEPTH), address width (derived; do not override)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- re  input  1  read request for register addr
- we  input  1  write request: capture data_bus into register addr
- inc  input  1  increment register addr by 1
- dec  input  1  decrement register addr by 1
- addr  input  AW  register select for re/we/inc/dec
- tap_addr  input  AW  register shown on q
- data_bus  inout  WIDTH  shared bus; driven only during the read window, else high-Z
- q  output  WIDTH  combinational view of register tap_addr
- zero  output  1  high when q == 0
- wrap  output  1  one-cycle pulse: the previous cycle's inc/dec wrapped
- err  output  1  sticky: re and we were asserted together

## Operation

- Reset (rst=0 at a rising edge):
  - All registers are cleared to 0.
  - The drive enable, wrap and err outputs are cleared to 0.
  - data_bus is released to high-Z.
  - Reset has priority over every other input.
- Per-edge update of register addr. Priority is we > inc/dec:
  - we=1: reg[addr] ← data_bus. Any inc or dec in the same cycle is ignored.
  - we=0, inc=1, dec=0: reg[addr] ← reg[addr]+1, modulo 2^WIDTH.
  - we=0, inc=0, dec=1: reg[addr] ← reg[addr]−1, modulo 2^WIDTH.
  - inc=1 and dec=1 together: no change, no wrap.
- Wrap flag:
  - wrap ← 1 when inc is applied to all-ones, or dec is applied to 0. Otherwise wrap ← 0.
  - wrap is a registered single-cycle pulse.
- Read:
  - re=1 sampled at edge N loads an output latch with reg[addr], using the value before any update at edge N.
  - The drive enable is set at edge N.
  - data_bus carries the latched value from edge N until edge N+1.
  - Back-to-back re cycles keep the bus driven, with each cycle's data refreshed.
  - re=0 at an edge clears the drive enable, and the bus returns to high-Z.
- Conflict:
  - re=1 and we=1 at the same edge: the write proceeds, the read is suppressed (no drive enable), and err ← 1.
  - err stays at 1 until reset.
- Bus ownership: the external driver must release data_bus on any cycle where the bank's drive enable is set. The bank never drives during a write.
- addr and tap_addr values ≥ DEPTH, when DEPTH is not a power of 2: writes, inc and dec are ignored, reads return 0, and q returns 0.
- q and zero are combinational from the register array and tap_addr. They reflect an update in the cycle after the edge that performed it.

## Timing

- Write latency: 1 edge. Data on the bus at edge N is visible on q after edge N when tap_addr == addr.
- Read latency: the bus is driven starting after edge N, where re is sampled at edge N. The drive window lasts one cycle per re cycle.
- inc/dec latency: 1 edge. wrap is valid in the cycle after the wrapping edge and clears 1 edge later unless the wrap repeats.
- A read and an inc/dec to the same addr at the same edge: the bus shows the pre-update value, and q shows the post-update value.
- Reset mid-read: the bus goes high-Z from the reset edge onward.
- Reset mid-write: the register is cleared and the written data is lost.

## Test plan

- Reset: hold rst=0 for 2 cycles with we=1 and data_bus=8'hFF.
  - Required: all registers read 0, zero=1, err=0, wrap=0, data_bus is Z.
- Write then read:
  - Write 8'hA5 to reg 1 and 8'h3C to reg 2, then release the bus.
  - Assert re with addr=1 for one cycle: data_bus=8'hA5 for exactly one cycle, then Z.
  - Repeat with addr=2: data_bus=8'h3C.
- Increment wrap: write 8'hFE to reg 3, then inc for 2 cycles.
  - Required: q goes 8'hFF, then 8'h00.
  - wrap is high only in the cycle after the second inc, and zero=1.
- Decrement wrap, plus inc and dec together:
  - dec on 0 gives 8'hFF with a wrap pulse.
  - inc and dec together leave 8'hFF unchanged with wrap=0.
- Priority and conflict:
  - we=1, inc=1, data_bus=8'h10: reg becomes 8'h10.
  - Next cycle, re=1, we=1, data_bus=8'h20: reg becomes 8'h20, the bank does not drive the bus, and err=1.
  - err stays at 1 through 10 idle cycles and clears on reset.
- Back-to-back reads with concurrent inc on the same register (start value 8'h05), re and inc held for 3 cycles:
  - Required: the bus shows 8'h05, 8'h06, 8'h07 on consecutive cycles, and q ends at 8'h08.
